sgdmac_desc_sequencer: RTL and testbench

Descriptor-chain sequencer for the scatter-gather DMA engine. On a start pulse from the APB configuration block, it walks a linked list of 16-byte descriptors in memory, beginning at the programmed start pointer. For each descriptor it issues one copy command to the DMA data mover and waits for that command to complete. It then reports chain completion back to the configuration block through its done status.

---
 rtl/sgdmac_desc_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_sgdmac_desc_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sgdmac_desc_sequencer.sv
// sgdmac_desc_sequencer: walks a linked list of 16-byte descriptors and issues
// one copy command per descriptor to the DMA data mover.
module sgdmac_desc_sequencer #(
  parameter int unsigned MAX_DESC = 256,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] start_pointer_i,
  input  logic              start_i,
  output logic              done_o,
  output logic              err_o,
  output logic [15:0]       desc_cnt_o,
  output logic              rd_req_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic              rd_gnt_i,
  input  logic              rd_rvalid_i,
  input  logic [31:0]       rd_rdata_i,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  output logic [ADDR_W-1:0] cmd_src_o,
  output logic [ADDR_W-1:0] cmd_dst_o,
  output logic [15:0]       cmd_len_o,
  input  logic              cmd_done_i
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned WIDX_W = 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_REQ    = 3'd1,
    RD_WAIT   = 3'd2,
    CMD       = 3'd3,
    WAIT_DONE = 3'd4
  } state_e;

  state_e              state_q,     state_d;
  logic [ADDR_W-1:0]   cur_ptr_q,   cur_ptr_d;
  logic [WIDX_W-1:0]   widx_q,      widx_d;
  logic [ADDR_W-1:0]   src_q,       src_d;
  logic [ADDR_W-1:0]   dst_q,       dst_d;
  logic [LEN_W-1:0]    len_q,       len_d;
  logic [ADDR_W-1:0]   next_q,      next_d;
  logic                done_q,      done_d;
  logic                err_q,       err_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic                rd_req_q,    rd_req_d;
  logic [ADDR_W-1:0]   rd_addr_q,   rd_addr_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic [ADDR_W-1:0]   cmd_src_q,   cmd_src_d;
  logic [ADDR_W-1:0]   cmd_dst_q,   cmd_dst_d;
  logic [LEN_W-1:0]    cmd_len_q,   cmd_len_d;

  // Next-pointer evaluation inputs, shared by the len==0 skip and WAIT_DONE paths
  logic                do_next;
  logic [ADDR_W-1:0]   nxt_ptr;
  logic [CNT_W-1:0]    nxt_cnt;
  logic [CNT_W-1:0]    cnt_inc;
  logic [WIDX_W-1:0]   widx_inc;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_ptr_q   <= '0;
      widx_q      <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      next_q      <= '0;
      done_q      <= 1'b1;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      cmd_valid_q <= 1'b0;
      cmd_src_q   <= '0;
      cmd_dst_q   <= '0;
      cmd_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_ptr_q   <= cur_ptr_d;
      widx_q      <= widx_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      next_q      <= next_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_src_q   <= cmd_src_d;
      cmd_dst_q   <= cmd_dst_d;
      cmd_len_q   <= cmd_len_d;
    end
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    cur_ptr_d   = cur_ptr_q;
    widx_d      = widx_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    next_d      = next_q;
    done_d      = done_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    rd_req_d    = rd_req_q;
    rd_addr_d   = rd_addr_q;
    cmd_valid_d = cmd_valid_q;
    cmd_src_d   = cmd_src_q;
    cmd_dst_d   = cmd_dst_q;
    cmd_len_d   = cmd_len_q;
    do_next     = 1'b0;
    nxt_ptr     = next_q;
    nxt_cnt     = cnt_q;
    widx_inc    = widx_q + WIDX_W'(1);
    cnt_inc     = (cnt_q == CNT_W'(MAX_DESC)) ? cnt_q : cnt_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          cur_ptr_d = start_pointer_i;
          err_d     = 1'b0;
          cnt_d     = '0;
          widx_d    = '0;
          if (start_pointer_i[3:0] != 4'h0) begin
            // Misaligned chain head: flag and stay idle without fetching
            err_d = 1'b1;
          end else begin
            done_d    = 1'b0;
            state_d   = RD_REQ;
            rd_req_d  = 1'b1;
            rd_addr_d = start_pointer_i;
          end
        end
      end

      RD_REQ: begin
        if (rd_gnt_i) begin
          rd_req_d = 1'b0;
          state_d  = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (rd_rvalid_i) begin
          unique case (widx_q)
            2'd0:    src_d  = ADDR_W'(rd_rdata_i);
            2'd1:    dst_d  = ADDR_W'(rd_rdata_i);
            2'd2:    len_d  = rd_rdata_i[LEN_W-1:0];
            default: next_d = ADDR_W'(rd_rdata_i);
          endcase
          if (widx_q != 2'd3) begin
            widx_d    = widx_inc;
            state_d   = RD_REQ;
            rd_req_d  = 1'b1;
            rd_addr_d = cur_ptr_q + ADDR_W'({widx_inc, 2'b00});
          end else begin
            cnt_d = cnt_inc;
            if (len_q == '0) begin
              // Empty descriptor: follow the link immediately
              do_next = 1'b1;
              nxt_ptr = ADDR_W'(rd_rdata_i);
              nxt_cnt = cnt_inc;
            end else begin
              state_d     = CMD;
              cmd_valid_d = 1'b1;
              cmd_src_d   = src_q;
              cmd_dst_d   = dst_q;
              cmd_len_d   = len_q;
            end
          end
        end
      end

      CMD: begin
        if (cmd_ready_i) begin
          cmd_valid_d = 1'b0;
          state_d     = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        if (cmd_done_i) begin
          do_next = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Link handling: terminate, misaligned link, loop limit, or continue
    if (do_next) begin
      if (nxt_ptr == '0) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else if (nxt_ptr[3:0] != 4'h0) begin
        err_d   = 1'b1;
        state_d = IDLE;
        done_d  = 1'b1;
      end else if (nxt_cnt == CNT_W'(MAX_DESC)) begin
        err_d   = 1'b1;
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        cur_ptr_d = nxt_ptr;
        widx_d    = '0;
        state_d   = RD_REQ;
        rd_req_d  = 1'b1;
        rd_addr_d = nxt_ptr;
      end
    end
  end

  assign done_o      = done_q;
  assign err_o       = err_q;
  assign desc_cnt_o  = cnt_q;
  assign rd_req_o    = rd_req_q;
  assign rd_addr_o   = rd_addr_q;
  assign cmd_valid_o = cmd_valid_q;
  assign cmd_src_o   = cmd_src_q;
  assign cmd_dst_o   = cmd_dst_q;
  assign cmd_len_o   = cmd_len_q;

endmodule

// File: tb/tb_sgdmac_desc_sequencer.sv
// Directed bench for sgdmac_desc_sequencer with a memory responder and a
// data-mover model that check every request against bench-built expectations.
module tb_sgdmac_desc_sequencer;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned MAX_DESC = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] start_pointer_i = '0;
  logic              start_i = 1'b0;
  logic              done_o;
  logic              err_o;
  logic [15:0]       desc_cnt_o;
  logic              rd_req_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic              rd_gnt_i = 1'b0;
  logic              rd_rvalid_i = 1'b0;
  logic [31:0]       rd_rdata_i = '0;
  logic              cmd_valid_o;
  logic              cmd_ready_i = 1'b0;
  logic [ADDR_W-1:0] cmd_src_o;
  logic [ADDR_W-1:0] cmd_dst_o;
  logic [15:0]       cmd_len_o;
  logic              cmd_done_i = 1'b0;

  sgdmac_desc_sequencer #(.MAX_DESC(MAX_DESC), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .start_pointer_i(start_pointer_i), .start_i(start_i),
    .done_o(done_o), .err_o(err_o), .desc_cnt_o(desc_cnt_o),
    .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o), .rd_gnt_i(rd_gnt_i),
    .rd_rvalid_i(rd_rvalid_i), .rd_rdata_i(rd_rdata_i),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .cmd_src_o(cmd_src_o), .cmd_dst_o(cmd_dst_o), .cmd_len_o(cmd_len_o),
    .cmd_done_i(cmd_done_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_rd[$];
  logic [31:0] exp_src[$];
  logic [31:0] exp_dst[$];
  logic [15:0] exp_len[$];
  int ridx = 0;
  int cidx = 0;
  int gnt_dly = 0;
  int rdy_dly = 0;
  int done_dly = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory responder: one outstanding read, configurable grant stall
  int          gcnt = 0;
  logic        pend = 1'b0;
  logic [31:0] paddr = '0;
  always @(negedge clk) begin
    if (rst) begin
      rd_gnt_i = 1'b0; rd_rvalid_i = 1'b0; rd_rdata_i = '0;
      pend = 1'b0; gcnt = 0;
    end else begin
      rd_rvalid_i = 1'b0;
      if (pend) begin
        rd_rvalid_i = 1'b1;
        rd_rdata_i  = mem.exists(paddr) ? mem[paddr] : 32'h0;
        pend = 1'b0;
      end
      rd_gnt_i = 1'b0;
      if (rd_req_o) begin
        if (ridx < exp_rd.size()) chk("rd_addr", rd_addr_o, exp_rd[ridx]);
        else chk("rd_extra", 32'(ridx), 32'(exp_rd.size()));
        if (gcnt == gnt_dly) begin
          rd_gnt_i = 1'b1; gcnt = 0; pend = 1'b1; paddr = rd_addr_o; ridx++;
        end else begin
          gcnt++;
        end
      end
    end
  end

  // Data-mover model: ready stall, completion pulse done_dly cycles later
  int rcnt = 0;
  int dcnt = 0;
  always @(negedge clk) begin
    cmd_done_i  = 1'b0;
    cmd_ready_i = 1'b0;
    if (rst) begin
      rcnt = 0; dcnt = 0;
    end else begin
      if (dcnt != 0) begin
        dcnt--;
        if (dcnt == 0) cmd_done_i = 1'b1;
      end
      if (cmd_valid_o) begin
        if (cidx < exp_src.size()) begin
          chk("cmd_src", cmd_src_o, exp_src[cidx]);
          chk("cmd_dst", cmd_dst_o, exp_dst[cidx]);
          chk("cmd_len", 32'(cmd_len_o), 32'(exp_len[cidx]));
        end else begin
          chk("cmd_extra", 32'(cidx), 32'(exp_src.size()));
        end
        if (rcnt == rdy_dly) begin
          cmd_ready_i = 1'b1; rcnt = 0; cidx++; dcnt = done_dly + 1;
        end else begin
          rcnt++;
        end
      end
    end
  end

  task automatic load_desc(input logic [31:0] a, input logic [31:0] s, input logic [31:0] d,
                           input logic [31:0] l, input logic [31:0] n);
    mem[a] = s; mem[a + 32'h4] = d; mem[a + 32'h8] = l; mem[a + 32'hC] = n;
  endtask

  task automatic expect_fetch(input logic [31:0] a);
    for (int i = 0; i < 4; i++) exp_rd.push_back(a + 32'(4 * i));
  endtask

  task automatic expect_cmd(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    exp_src.push_back(s); exp_dst.push_back(d); exp_len.push_back(l);
  endtask

  task automatic clear_exp();
    exp_rd.delete(); exp_src.delete(); exp_dst.delete(); exp_len.delete();
    ridx = 0; cidx = 0;
  endtask

  task automatic run_chain(input logic [31:0] ptr, output int cyc);
    start_pointer_i = ptr;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 0;
    while (done_o !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic end_chk(input string tag, input int cnt, input logic err,
                         input int nrd, input int ncmd);
    chk({tag, "_done"}, 32'(done_o), 32'h1);
    chk({tag, "_cnt"},  32'(desc_cnt_o), 32'(cnt));
    chk({tag, "_err"},  32'(err_o), 32'(err));
    chk({tag, "_nrd"},  32'(ridx), 32'(nrd));
    chk({tag, "_ncmd"}, 32'(cidx), 32'(ncmd));
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_done"},  32'(done_o), 32'h1);
    chk({tag, "_err"},   32'(err_o), 32'h0);
    chk({tag, "_cnt"},   32'(desc_cnt_o), 32'h0);
    chk({tag, "_rdreq"}, 32'(rd_req_o), 32'h0);
    chk({tag, "_rdadr"}, rd_addr_o, 32'h0);
    chk({tag, "_cval"},  32'(cmd_valid_o), 32'h0);
    chk({tag, "_csrc"},  cmd_src_o, 32'h0);
    chk({tag, "_cdst"},  cmd_dst_o, 32'h0);
    chk({tag, "_clen"},  32'(cmd_len_o), 32'h0);
  endtask

  // Overall time limit
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed test sequence
  initial begin
    int cyc;
    int k;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    reset_chk("rst");
    rst = 1'b0;
    @(negedge clk);

    // Single descriptor, zero-wait handshakes: 8 fetch + 1 cmd + 1 done cycles
    load_desc(32'h1000, 32'h2000, 32'h3000, 32'h40, 32'h0);
    clear_exp();
    expect_fetch(32'h1000);
    expect_cmd(32'h2000, 32'h3000, 16'h40);
    run_chain(32'h1000, cyc);
    chk("single_cycles", 32'(cyc), 32'd10);
    end_chk("single", 1, 1'b0, 4, 1);

    // Three-descriptor chain with grant and ready stalls
    gnt_dly = 3; rdy_dly = 2; done_dly = 1;
    load_desc(32'h100, 32'hA000, 32'hB000, 32'h10, 32'h200);
    load_desc(32'h200, 32'hA100, 32'hB100, 32'h20, 32'h300);
    load_desc(32'h300, 32'hA200, 32'hB200, 32'h30, 32'h0);
    clear_exp();
    expect_fetch(32'h100); expect_fetch(32'h200); expect_fetch(32'h300);
    expect_cmd(32'hA000, 32'hB000, 16'h10);
    expect_cmd(32'hA100, 32'hB100, 16'h20);
    expect_cmd(32'hA200, 32'hB200, 16'h30);
    run_chain(32'h100, cyc);
    end_chk("chain3", 3, 1'b0, 12, 3);

    // Middle descriptor has len 0 (upper len-word bits ignored)
    gnt_dly = 0; rdy_dly = 0; done_dly = 0;
    load_desc(32'h1100, 32'hC000, 32'hD000, 32'hABCD0010, 32'h1200);
    load_desc(32'h1200, 32'hC100, 32'hD100, 32'hFFFF0000, 32'h1300);
    load_desc(32'h1300, 32'hC200, 32'hD200, 32'h24, 32'h0);
    clear_exp();
    expect_fetch(32'h1100); expect_fetch(32'h1200); expect_fetch(32'h1300);
    expect_cmd(32'hC000, 32'hD000, 16'h10);
    expect_cmd(32'hC200, 32'hD200, 16'h24);
    run_chain(32'h1100, cyc);
    end_chk("len0", 3, 1'b0, 12, 2);

    // Misaligned start pointer: no fetch, error, done never drops
    clear_exp();
    run_chain(32'h1004, cyc);
    chk("misal_start_cycles", 32'(cyc), 32'd0);
    repeat (4) @(negedge clk);
    end_chk("misal_start", 0, 1'b1, 0, 0);

    // Misaligned next pointer after one completed copy
    load_desc(32'h400, 32'h4000, 32'h4400, 32'h4, 32'h208);
    clear_exp();
    expect_fetch(32'h400);
    expect_cmd(32'h4000, 32'h4400, 16'h4);
    run_chain(32'h400, cyc);
    end_chk("misal_next", 1, 1'b1, 4, 1);

    // Self-loop stops at MAX_DESC
    load_desc(32'h500, 32'h5000, 32'h6000, 32'h8, 32'h500);
    clear_exp();
    for (int i = 0; i < 4; i++) begin
      expect_fetch(32'h500);
      expect_cmd(32'h5000, 32'h6000, 16'h8);
    end
    run_chain(32'h500, cyc);
    end_chk("selfloop", 4, 1'b1, 16, 4);

    // start pulse during WAIT_DONE is ignored
    done_dly = 6;
    clear_exp();
    expect_fetch(32'h1000);
    expect_cmd(32'h2000, 32'h3000, 16'h40);
    start_pointer_i = 32'h1000;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    k = 0;
    while (cidx < 1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk("busy_done_low", 32'(done_o), 32'h0);
    start_pointer_i = 32'h1100;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    k = 0;
    while (done_o !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    end_chk("busy_start", 1, 1'b0, 4, 1);

    // Reset while waiting for read data, then a clean rerun
    done_dly = 0;
    clear_exp();
    expect_fetch(32'h1000);
    start_pointer_i = 32'h1000;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    chk("rdwait_rdreq", 32'(rd_req_o), 32'h0);
    chk("rdwait_done", 32'(done_o), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    reset_chk("midrst");
    rst = 1'b0;
    @(negedge clk);
    clear_exp();
    expect_fetch(32'h1000);
    expect_cmd(32'h2000, 32'h3000, 16'h40);
    run_chain(32'h1000, cyc);
    chk("rerun_cycles", 32'(cyc), 32'd10);
    end_chk("rerun", 1, 1'b0, 4, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
